// File: rtl/add_sub_iter.sv
// Multi-cycle signed/unsigned adder-subtractor: one BLOCK-bit slice per clock through a
// single ripple slice with block-propagate skip. Optional saturation via `define ADDSUB_SAT_EN.
module add_sub_iter #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] xa, yb, work, res;
    logic             c;
    logic [KW-1:0]    k;
    logic             last;

    logic [BLOCK-1:0] a_k, b_k, s_k;
    logic             g_k, p_k, c_nxt, c_msb_k, ovf_n, msb_n;
    logic [WIDTH:0]   sum_n;

    assign last = (k == KW'(NBLK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: state_nxt = start ? RUN : IDLE;
            RUN: begin
                ready = 1'b0;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One slice: full ripple with the live carry for the sum bits and the carry into the
    // top bit, plus a zero-carry ripple for g_k so the skip term can select the carry-out.
    always_comb begin
        logic rc, gc;
        a_k     = xa[int'(k)*BLOCK +: BLOCK];
        b_k     = yb[int'(k)*BLOCK +: BLOCK];
        s_k     = '0;
        rc      = c;
        gc      = 1'b0;
        c_msb_k = c;
        for (int i = 0; i < BLOCK; i++) begin
            s_k[i]  = a_k[i] ^ b_k[i] ^ rc;
            c_msb_k = rc;
            rc      = (a_k[i] & b_k[i]) | (rc & (a_k[i] ^ b_k[i]));
            gc      = (a_k[i] & b_k[i]) | (gc & (a_k[i] ^ b_k[i]));
        end
        g_k   = gc;
        p_k   = &(a_k ^ b_k);
        c_nxt = g_k | (p_k & c);

        res                          = work;
        res[int'(k)*BLOCK +: BLOCK]  = s_k;
        ovf_n = c_msb_k ^ c_nxt;
        msb_n = xa[WIDTH-1] ^ yb[WIDTH-1] ^ c_nxt;
        sum_n = {msb_n, res};
`ifdef ADDSUB_SAT_EN
        if (ovf_n)
            sum_n = msb_n ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
`endif
    end

    // Outputs are only written on the final slice, so partial results never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa   <= '0;
            yb   <= '0;
            c    <= 1'b0;
            k    <= '0;
            work <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                xa   <= x;
                yb   <= op ? ~y : y;
                c    <= op ? ~cin : cin;
                k    <= '0;
                work <= '0;
            end
        end else begin
            work <= res;
            c    <= c_nxt;
            k    <= k + KW'(1);
            if (last) begin
                sum  <= sum_n;
                cout <= c_nxt;
                ovf  <= ovf_n;
                zero <= ~|sum_n[WIDTH-1:0];
                neg  <= sum_n[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_add_sub_iter.sv
// Directed bench for add_sub_iter: 32/8 and 16/4 instances, handshake timing and reset abort.
module tb_add_sub_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st32 = 0, op32 = 0, ci32 = 0;
    logic [31:0] x32 = '0, y32 = '0;
    logic        rdy32, dn32, co32, ov32, z32, n32;
    logic [32:0] sum32;

    logic        st16 = 0, op16 = 0, ci16 = 0;
    logic [15:0] x16 = '0, y16 = '0;
    logic        rdy16, dn16, co16, ov16, z16, n16;
    logic [16:0] sum16;

    int nvec = 0;
    int nerr = 0;

    add_sub_iter #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .op(op32), .cin(ci32), .x(x32), .y(y32),
        .ready(rdy32), .done(dn32), .sum(sum32), .cout(co32), .ovf(ov32), .zero(z32), .neg(n32));

    add_sub_iter #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .op(op16), .cin(ci16), .x(x16), .y(y16),
        .ready(rdy16), .done(dn16), .sum(sum16), .cout(co16), .ovf(ov16), .zero(z16), .neg(n16));

    // Called just after a negedge; returns just after the negedge where done is seen.
    // lat counts negedges after the accepting edge (expected NBLK+1), -1 on timeout.
    task automatic run32(input logic o, input logic ci, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        st32 = 1; op32 = o; ci32 = ci; x32 = a; y32 = b;
        @(negedge clk);
        st32 = 0;
        lat = 1;
        while (!dn32 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!dn32) lat = -1;
    endtask

    task automatic test_reset;
        nvec++; if (sum32 !== 33'h0) begin nerr++; $display("FAIL reset_sum: got %h want 0", sum32); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b0) begin nerr++; $display("FAIL reset_flags: got %b want 0000", {co32, ov32, z32, n32}); end
        nvec++; if (dn32 !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", dn32); end
        nvec++; if (rdy32 !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", rdy32); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_add;
        int lat;
        run32(1'b0, 1'b0, 32'h5, 32'h3, lat);
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL add_latency: got %0d want 5", lat); end
        nvec++; if (sum32 !== 33'h0_00000008) begin nerr++; $display("FAIL add_sum: got %h want 000000008", sum32); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b0000) begin nerr++; $display("FAIL add_flags: got %b want 0000", {co32, ov32, z32, n32}); end
        nvec++; if (rdy32 !== 1'b1) begin nerr++; $display("FAIL add_ready_done: got %b want 1", rdy32); end
        @(negedge clk);
        nvec++; if (dn32 !== 1'b0) begin nerr++; $display("FAIL add_done_pulse: got %b want 0", dn32); end
        nvec++; if (sum32 !== 33'h0_00000008) begin nerr++; $display("FAIL add_hold: got %h want 000000008", sum32); end
    endtask

    task automatic test_sub;
        int lat;
        run32(1'b1, 1'b0, 32'h5, 32'h7, lat);
        nvec++; if (sum32 !== 33'h1_FFFFFFFE) begin nerr++; $display("FAIL sub_sum: got %h want 1fffffffe", sum32); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b0001) begin nerr++; $display("FAIL sub_flags: got %b want 0001", {co32, ov32, z32, n32}); end
        // 10 - 3 - borrow 1 = 6, no borrow out
        run32(1'b1, 1'b1, 32'hA, 32'h3, lat);
        nvec++; if (sum32 !== 33'h0_00000006) begin nerr++; $display("FAIL sub_borrow_sum: got %h want 000000006", sum32); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b1000) begin nerr++; $display("FAIL sub_borrow_flags: got %b want 1000", {co32, ov32, z32, n32}); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int lat;
        logic [32:0] exp_sum;
`ifdef ADDSUB_SAT_EN
        exp_sum = 33'h0_7FFFFFFF;
`else
        exp_sum = 33'h0_80000000;
`endif
        run32(1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, lat);
        nvec++; if (sum32 !== exp_sum) begin nerr++; $display("FAIL ovf_sum: got %h want %h", sum32, exp_sum); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b0100) begin nerr++; $display("FAIL ovf_flags: got %b want 0100", {co32, ov32, z32, n32}); end
        @(negedge clk);
    endtask

    task automatic test_skip_chain;
        int lat;
        run32(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, lat);
        nvec++; if (sum32 !== 33'h0) begin nerr++; $display("FAIL skip_sum: got %h want 000000000", sum32); end
        nvec++; if ({co32, ov32, z32, n32} !== 4'b1010) begin nerr++; $display("FAIL skip_flags: got %b want 1010", {co32, ov32, z32, n32}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        run32(1'b0, 1'b0, 32'h5, 32'h3, lat);
        run32(1'b1, 1'b0, 32'h100, 32'h1, lat);
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        nvec++; if (sum32 !== 33'h0_000000FF) begin nerr++; $display("FAIL b2b_sum: got %h want 0000000ff", sum32); end
        nvec++; if (co32 !== 1'b1) begin nerr++; $display("FAIL b2b_cout: got %b want 1", co32); end
        @(negedge clk);
    endtask

    task automatic test_start_in_run;
        int lat;
        st32 = 1; op32 = 0; ci32 = 0; x32 = 32'h10; y32 = 32'h20;
        @(negedge clk);
        st32 = 1; op32 = 1; x32 = 32'h99; y32 = 32'h1;
        nvec++; if (rdy32 !== 1'b0) begin nerr++; $display("FAIL run_ready: got %b want 0", rdy32); end
        nvec++; if (sum32 !== 33'h0_000000FF) begin nerr++; $display("FAIL run_outputs_hold: got %h want 0000000ff", sum32); end
        @(negedge clk);
        st32 = 0;
        lat = 2;
        while (!dn32 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL run_ignore_latency: got %0d want 5", lat); end
        nvec++; if (sum32 !== 33'h0_00000030) begin nerr++; $display("FAIL run_ignore_sum: got %h want 000000030", sum32); end
        @(negedge clk);
        nvec++; if (dn32 !== 1'b0) begin nerr++; $display("FAIL run_no_second_done: got %b want 0", dn32); end
    endtask

    task automatic test_reset_in_run;
        int seen;
        st32 = 1; op32 = 0; ci32 = 0; x32 = 32'h1; y32 = 32'h1;
        @(negedge clk);
        st32 = 0;
        @(negedge clk);
        rst = 1;
        #1;
        nvec++; if (sum32 !== 33'h0) begin nerr++; $display("FAIL rstrun_sum: got %h want 0", sum32); end
        nvec++; if ({co32, ov32, z32, n32, dn32} !== 5'b0) begin nerr++; $display("FAIL rstrun_flags: got %b want 00000", {co32, ov32, z32, n32, dn32}); end
        nvec++; if (rdy32 !== 1'b1) begin nerr++; $display("FAIL rstrun_ready: got %b want 1", rdy32); end
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dn32) seen++;
        end
        nvec++; if (seen !== 0) begin nerr++; $display("FAIL rstrun_no_done: got %0d want 0", seen); end
    endtask

    task automatic test_w16;
        int lat;
        logic [16:0] exp_sum;
`ifdef ADDSUB_SAT_EN
        exp_sum = 17'h1_8000;
`else
        exp_sum = 17'h1_7FFF;
`endif
        st16 = 1; op16 = 1; ci16 = 0; x16 = 16'h8000; y16 = 16'h0001;
        @(negedge clk);
        st16 = 0;
        lat = 1;
        while (!dn16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!dn16) lat = -1;
        nvec++; if (lat !== 5) begin nerr++; $display("FAIL w16_latency: got %0d want 5", lat); end
        nvec++; if (sum16 !== exp_sum) begin nerr++; $display("FAIL w16_sum: got %h want %h", sum16, exp_sum); end
        nvec++; if ({co16, ov16} !== 2'b11) begin nerr++; $display("FAIL w16_cout_ovf: got %b want 11", {co16, ov16}); end
        nvec++; if (n16 !== 1'b1) begin nerr++; $display("FAIL w16_neg: got %b want 1", n16); end
        @(negedge clk);
    endtask

    initial begin
        #1;
        test_reset;
        test_add;
        test_sub;
        test_overflow;
        test_skip_chain;
        test_back_to_back;
        test_start_in_run;
        test_reset_in_run;
        test_w16;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
